// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/memory handshake bundle between the RV32I pipeline datapath and its stall/flush sequencer.
// master = datapath side (raises requests, consumes enables); slave = pipeline_stall_ctrl.
interface pipeline_stall_ctrl_if;
   logic ld_use_stall;
   logic br_taken;
   logic dmem_req;
   logic dmem_ack;
   logic pc_en;
   logic if_id_en;
   logic id_ex_en;
   logic ex_mem_en;
   logic mem_wb_en;
   logic if_id_flush;
   logic id_ex_flush;
   logic ex_mem_flush;
   logic mem_err;

   modport master (
      output ld_use_stall, br_taken, dmem_req, dmem_ack,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
      input  if_id_flush, id_ex_flush, ex_mem_flush, mem_err
   );

   modport slave (
      input  ld_use_stall, br_taken, dmem_req, dmem_ack,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
      output if_id_flush, id_ex_flush, ex_mem_flush, mem_err
   );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline with memory-wait FSM and bus watchdog.
// Optional perf counters are built when the macro PIPE_PERF_EN is defined.
module pipeline_stall_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pipeline_stall_ctrl_if.slave   bus
`ifdef PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0]       perf_stall_cyc,
   output logic [CNT_W-1:0]       perf_flush_cnt
`endif
);

   localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1) + 1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ABORT    = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WC_W-1:0]  r_wait_cnt;
   logic [WC_W-1:0]  w_wait_nxt;

   logic w_mem_stall;
   logic w_timeout;
   logic w_issue;

   logic w_pc_en;
   logic w_if_id_en;
   logic w_id_ex_en;
   logic w_ex_mem_en;
   logic w_mem_wb_en;
   logic w_if_id_flush;
   logic w_id_ex_flush;
   logic w_ex_mem_flush;
   logic w_mem_err;

   if (CNT_W < 1) begin : g_cnt_w_chk
      $error("pipeline_stall_ctrl: CNT_W must be at least 1");
   end

   assign w_mem_stall = bus.dmem_req & ~bus.dmem_ack;
   assign w_timeout   = (MEM_TIMEOUT != 0) && (r_wait_cnt == WC_W'(MEM_TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   always_comb begin
      w_next     = RUN;
      w_wait_nxt = '0;
      case (r_state)
         RUN: begin
            if (w_mem_stall) begin
               w_next     = MEM_WAIT;
               w_wait_nxt = WC_W'(1);
            end
         end
         MEM_WAIT: begin
            // Ack has priority over the watchdog firing in the same cycle.
            if (bus.dmem_ack) begin
               w_next     = RUN;
               w_wait_nxt = '0;
            end else if (w_timeout) begin
               w_next     = ABORT;
               w_wait_nxt = '0;
            end else begin
               w_next     = MEM_WAIT;
               w_wait_nxt = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + WC_W'(1);
            end
         end
         ABORT: begin
            w_next     = RUN;
            w_wait_nxt = '0;
         end
         default: begin
            w_next     = RUN;
            w_wait_nxt = '0;
         end
      endcase
   end

   always_comb begin
      w_pc_en        = 1'b0;
      w_if_id_en     = 1'b0;
      w_id_ex_en     = 1'b0;
      w_ex_mem_en    = 1'b0;
      w_mem_wb_en    = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_flush  = 1'b0;
      w_ex_mem_flush = 1'b0;
      w_mem_err      = 1'b0;
      w_issue        = 1'b0;

      if (rst_n) begin
         case (r_state)
            RUN:      w_issue = ~w_mem_stall;
            MEM_WAIT: w_issue = bus.dmem_ack;
            ABORT: begin
               w_mem_err      = 1'b1;
               w_pc_en        = 1'b1;
               w_if_id_en     = 1'b1;
               w_id_ex_en     = 1'b1;
               w_ex_mem_en    = 1'b1;
               w_mem_wb_en    = 1'b1;
               w_if_id_flush  = 1'b1;
               w_id_ex_flush  = 1'b1;
               w_ex_mem_flush = 1'b1;
            end
            default:  w_issue = ~w_mem_stall;
         endcase

         // Release from a stall (or no stall at all) applies the redirect/load-use rules.
         if (w_issue) begin
            w_id_ex_en  = 1'b1;
            w_ex_mem_en = 1'b1;
            w_mem_wb_en = 1'b1;
            if (bus.br_taken) begin
               w_pc_en       = 1'b1;
               w_if_id_en    = 1'b1;
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
            end else if (bus.ld_use_stall) begin
               w_id_ex_flush = 1'b1;
            end else begin
               w_pc_en    = 1'b1;
               w_if_id_en = 1'b1;
            end
         end
      end
   end

   assign bus.pc_en        = w_pc_en;
   assign bus.if_id_en     = w_if_id_en;
   assign bus.id_ex_en     = w_id_ex_en;
   assign bus.ex_mem_en    = w_ex_mem_en;
   assign bus.mem_wb_en    = w_mem_wb_en;
   assign bus.if_id_flush  = w_if_id_flush;
   assign bus.id_ex_flush  = w_id_ex_flush;
   assign bus.ex_mem_flush = w_ex_mem_flush;
   assign bus.mem_err      = w_mem_err;

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] r_perf_stall;
   logic [CNT_W-1:0] r_perf_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
      end else begin
         if (!w_pc_en && (r_perf_stall != '1)) begin
            r_perf_stall <= r_perf_stall + CNT_W'(1);
         end
         if (w_if_id_flush && (r_perf_flush != '1)) begin
            r_perf_flush <= r_perf_flush + CNT_W'(1);
         end
      end
   end

   assign perf_stall_cyc = r_perf_stall;
   assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic vs a behavioural model.
module tb_pipeline_stall_ctrl;
   localparam int unsigned TO = 4;

   localparam logic [8:0] E_STALL = 9'h000;
   localparam logic [8:0] E_IDLE  = 9'h1F0;
   localparam logic [8:0] E_LDUSE = 9'h074;
   localparam logic [8:0] E_BR    = 9'h1FC;
   localparam logic [8:0] E_ABORT = 9'h1FF;

   logic clk;
   logic rst_n;
   pipeline_stall_ctrl_if bus();

`ifdef PIPE_PERF_EN
   logic [31:0] perf_stall_cyc;
   logic [31:0] perf_flush_cnt;
`endif

   pipeline_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef PIPE_PERF_EN
      ,
      .perf_stall_cyc (perf_stall_cyc),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: how many cycles the current access has been stalled (0 = none), and a pending abort cycle.
   int m_waited  = 0;
   bit m_abort   = 0;
   int m_pstall  = 0;
   int m_pflush  = 0;

   // Bit order: pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes, mem_err
   function automatic logic [8:0] model_out(bit r, bit ld, bit br, bit req, bit ack);
      bit stalled;
      if (!r) return E_STALL;
      if (m_abort) return E_ABORT;
      stalled = (m_waited == 0) ? (req && !ack) : !ack;
      if (stalled) return E_STALL;
      if (br) return E_BR;
      if (ld) return E_LDUSE;
      return E_IDLE;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit ld, input bit br, input bit req, input bit ack,
                       input bit use_lit, input logic [8:0] lit, input string nm);
      logic [8:0] exp;
      logic [8:0] act;
      rst_n            = r;
      bus.ld_use_stall = ld;
      bus.br_taken     = br;
      bus.dmem_req     = req;
      bus.dmem_ack     = ack;
      if (!r) begin
         m_waited = 0;
         m_abort  = 0;
         m_pstall = 0;
         m_pflush = 0;
      end
      @(negedge clk);
      exp = model_out(r, ld, br, req, ack);
      act = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
             bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_err};
      check(nm, 32'(act), 32'(exp));
      if (use_lit) check({nm, "_lit"}, 32'(act), 32'(lit));
`ifdef PIPE_PERF_EN
      check({nm, "_perf_stall"}, perf_stall_cyc, 32'(m_pstall));
      check({nm, "_perf_flush"}, perf_flush_cnt, 32'(m_pflush));
`endif
      @(posedge clk);
      if (r) begin
         if (!exp[8]) m_pstall++;
         if (exp[3])  m_pflush++;
         if (m_abort) begin
            m_abort  = 0;
            m_waited = 0;
         end else if (m_waited > 0) begin
            if (ack) m_waited = 0;
            else if (TO != 0 && m_waited == int'(TO)) begin
               m_abort  = 1;
               m_waited = 0;
            end else m_waited++;
         end else if (req && !ack) begin
            m_waited = 1;
         end
      end
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.ld_use_stall = 1'b0;
      bus.br_taken = 1'b0;
      bus.dmem_req = 1'b0;
      bus.dmem_ack = 1'b0;
      @(posedge clk);
      #1;
      step(0, 0, 0, 0, 0, 1, E_STALL, "reset0");
      step(0, 1, 1, 1, 0, 1, E_STALL, "reset1");
      step(1, 0, 0, 0, 0, 1, E_IDLE,  "idle");
      // load-use bubble then resume
      step(1, 1, 0, 0, 0, 1, E_LDUSE, "lduse");
      step(1, 0, 0, 0, 0, 1, E_IDLE,  "lduse_after");
      // branch beats load-use
      step(1, 1, 1, 0, 0, 1, E_BR,    "br_ld");
      // zero-wait access
      step(1, 0, 0, 1, 1, 1, E_IDLE,  "zero_wait");
      // ack after wait
      step(1, 0, 0, 1, 0, 1, E_STALL, "wait_req");
      step(1, 0, 0, 1, 0, 1, E_STALL, "wait_1");
      step(1, 0, 0, 1, 0, 1, E_STALL, "wait_2");
      step(1, 0, 0, 1, 1, 1, E_IDLE,  "wait_ack");
      step(1, 0, 0, 0, 0, 1, E_IDLE,  "wait_run");
      // watchdog abort
      step(1, 0, 0, 1, 0, 1, E_STALL, "to_req");
      for (int i = 1; i <= 4; i++) step(1, 0, 0, 1, 0, 1, E_STALL, "to_wait");
      step(1, 1, 0, 1, 0, 1, E_ABORT, "to_abort");
      step(1, 0, 0, 0, 0, 1, E_IDLE,  "to_run");
      // ack on timeout cycle: held load-use takes effect, no abort
      step(1, 0, 0, 1, 0, 1, E_STALL, "tack_req");
      for (int i = 1; i <= 3; i++) step(1, 1, 0, 1, 0, 1, E_STALL, "tack_wait");
      step(1, 1, 0, 1, 1, 1, E_LDUSE, "tack_ack");
      step(1, 0, 0, 0, 0, 1, E_IDLE,  "tack_run");
      // reset mid wait
      step(1, 0, 0, 1, 0, 1, E_STALL, "rst_req");
      step(1, 0, 0, 1, 0, 1, E_STALL, "rst_wait");
      step(0, 0, 0, 1, 0, 1, E_STALL, "rst_mid");
      step(1, 0, 0, 0, 0, 1, E_IDLE,  "rst_rel");

      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(63) != 0),
              ($urandom_range(3) == 0),
              ($urandom_range(5) == 0),
              ($urandom_range(1) == 0),
              ($urandom_range(2) == 0),
              0, E_STALL, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
